// File: rtl/tour_seq_pkg.sv
// Shared types and constants for the tour command sequencer.
package tour_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAL,
    ISSUE,
    WAIT_SNT,
    WAIT_RESP,
    CHECK,
    ERROR
  } state_t;

  localparam logic [7:0] POS_ACK = 8'hA5;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_NAK  = 2'b01;
  localparam logic [1:0] ERR_TO   = 2'b10;
  localparam logic [1:0] ERR_OVF  = 2'b11;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; a push is accepted while full when a pop happens on the same edge.
module cmd_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head_c,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head_c  = mem[rd_ptr];

  // Pointers and occupancy; full/empty are kept as registers beside cnt.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10: begin
          cnt   <= cnt + CW'(1);
          full  <= (cnt == CW'(DEPTH - 1));
          empty <= 1'b0;
        end
        2'b01: begin
          cnt   <= cnt - CW'(1);
          full  <= 1'b0;
          empty <= (cnt == CW'(1));
        end
        default: ;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Plays a queued list of Knight commands to RemoteComm, one at a time, with ack check,
// timeout retry and optional gyro calibration at the start of each run.
module tour_cmd_sequencer
  import tour_seq_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] TO_CYCLES = 32'd50_000_000,
  parameter bit          FAST_SIM  = 1'b1,
  parameter int unsigned MAX_RETRY = 2,
  parameter bit          AUTO_CAL  = 1'b1,
  parameter logic [15:0] CAL_CMD   = 16'h2000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            cmd_in,
  input  logic                   cmd_wr,
  output logic                   q_full,
  output logic [$clog2(DEPTH):0] q_cnt,
  input  logic                   start,
  input  logic                   abort,
  output logic [15:0]            cmd,
  output logic                   snd_cmd,
  input  logic                   cmd_snt,
  input  logic                   resp_rdy,
  input  logic [7:0]             resp,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic [7:0]             cmds_ok
);

  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [31:0] EFF_TO = FAST_SIM ? (TO_CYCLES >> 8) : TO_CYCLES;

  state_t         state;
  logic [RW-1:0]  retry;
  logic [31:0]    to_cnt;
  logic [7:0]     resp_q;

  logic [15:0]    head_c;
  logic           fifo_empty;
  logic           pop_c;
  logic           flush_c;
  logic           ovf_c;

  assign flush_c = abort && (state != IDLE);
  assign pop_c   = (state == ISSUE) && !fifo_empty && !abort;
  assign ovf_c   = cmd_wr && q_full && !pop_c;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush_c),
    .push   (cmd_wr),
    .pop    (pop_c),
    .din    (cmd_in),
    .head_c (head_c),
    .full   (q_full),
    .empty  (fifo_empty),
    .cnt    (q_cnt)
  );

  // Sequencer FSM with registered outputs; abort overrides every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cmd      <= '0;
      snd_cmd  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      cmds_ok  <= '0;
      retry    <= '0;
      to_cnt   <= '0;
      resp_q   <= '0;
    end else begin
      snd_cmd <= 1'b0;
      done    <= 1'b0;

      if (flush_c) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              err      <= 1'b0;
              err_code <= ERR_NONE;
              cmds_ok  <= '0;
              if (AUTO_CAL) begin
                busy  <= 1'b1;
                state <= CAL;
              end else if (fifo_empty) begin
                done <= 1'b1;
              end else begin
                busy  <= 1'b1;
                state <= ISSUE;
              end
            end
          end

          CAL: begin
            cmd     <= CAL_CMD;
            snd_cmd <= 1'b1;
            retry   <= '0;
            state   <= WAIT_SNT;
          end

          ISSUE: begin
            if (fifo_empty) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              cmd     <= head_c;
              snd_cmd <= 1'b1;
              retry   <= '0;
              state   <= WAIT_SNT;
            end
          end

          WAIT_SNT: begin
            if (cmd_snt) begin
              to_cnt <= '0;
              state  <= WAIT_RESP;
            end
          end

          // A response arriving on the expiry cycle is taken over the timeout.
          WAIT_RESP: begin
            if (resp_rdy) begin
              resp_q <= resp;
              state  <= CHECK;
            end else if (to_cnt >= EFF_TO) begin
              if (retry < RW'(MAX_RETRY)) begin
                retry   <= retry + RW'(1);
                snd_cmd <= 1'b1;
                state   <= WAIT_SNT;
              end else begin
                err      <= 1'b1;
                err_code <= ERR_TO;
                busy     <= 1'b0;
                state    <= ERROR;
              end
            end else if (to_cnt != 32'hFFFF_FFFF) begin
              to_cnt <= to_cnt + 32'd1;
            end
          end

          CHECK: begin
            if (resp_q == POS_ACK) begin
              if (cmds_ok != 8'hFF) cmds_ok <= cmds_ok + 8'd1;
              state <= ISSUE;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_NAK;
              busy     <= 1'b0;
              state    <= ERROR;
            end
          end

          // Resume from the queue head; the acked count carries over.
          ERROR: begin
            if (start) begin
              err      <= 1'b0;
              err_code <= ERR_NONE;
              busy     <= 1'b1;
              state    <= ISSUE;
            end
          end

          default: state <= IDLE;
        endcase
      end

      if (ovf_c) begin
        err      <= 1'b1;
        err_code <= ERR_OVF;
      end
    end
  end

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Directed bench for tour_cmd_sequencer with an inline RemoteComm handshake model.
module tb_tour_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd_in;
  logic        cmd_wr;
  logic        q_full;
  logic [4:0]  q_cnt;
  logic        start;
  logic        abort;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  cmds_ok;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int snd_cnt = 0;
  int t_snd = 0;
  int t_snt = 0;

  tour_cmd_sequencer #(
    .DEPTH     (16),
    .TO_CYCLES (32'd51200),
    .FAST_SIM  (1'b1),
    .MAX_RETRY (2),
    .AUTO_CAL  (1'b1),
    .CAL_CMD   (16'h2000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_in   (cmd_in),
    .cmd_wr   (cmd_wr),
    .q_full   (q_full),
    .q_cnt    (q_cnt),
    .start    (start),
    .abort    (abort),
    .cmd      (cmd),
    .snd_cmd  (snd_cmd),
    .cmd_snt  (cmd_snt),
    .resp_rdy (resp_rdy),
    .resp     (resp),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .cmds_ok  (cmds_ok)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (snd_cmd === 1'b1) snd_cnt <= snd_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    cmd_in = w;
    cmd_wr = 1'b1;
    tick();
    cmd_wr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_snd(input int max, output logic [15:0] c, output bit ok);
    ok = 1'b0;
    c = '0;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      if (snd_cmd === 1'b1) begin
        ok = 1'b1;
        c = cmd;
        t_snd = cyc;
      end
    end
  endtask

  task automatic send_snt();
    tick();
    tick();
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    t_snt = cyc;
  endtask

  task automatic reply(input logic [7:0] r);
    send_snt();
    tick();
    tick();
    tick();
    resp = r;
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_err(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      if (err === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({cmd, snd_cmd, busy, done, err} !== {16'h0000, 4'b0000}) begin
      failures++;
      $display("FAIL reset_ctl: cmd=%h snd=%b busy=%b done=%b err=%b, required all zero",
               cmd, snd_cmd, busy, done, err);
    end
    checks++;
    if ({err_code, cmds_ok, q_cnt, q_full} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_stat: err_code=%0d cmds_ok=%0d q_cnt=%0d q_full=%b, required zero",
               err_code, cmds_ok, q_cnt, q_full);
    end
  endtask

  task automatic test_basic_run();
    logic [15:0] c;
    logic [15:0] exp_w [3];
    bit ok;
    int d0, s0;
    exp_w[0] = 16'h2000;
    exp_w[1] = 16'h4BF4;
    exp_w[2] = 16'h5BF2;
    push(16'h4BF4);
    push(16'h5BF2);
    checks++;
    if (q_cnt !== 5'd2) begin
      failures++;
      $display("FAIL basic_qcnt: got %0d required 2", q_cnt);
    end
    d0 = done_cnt;
    s0 = snd_cnt;
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy: got %b required 1", busy);
    end
    for (int k = 0; k < 3; k++) begin
      wait_snd(20, c, ok);
      checks++;
      if (!ok || c !== exp_w[k]) begin
        failures++;
        $display("FAIL basic_cmd%0d: seen=%b cmd=%h required %h", k, ok, c, exp_w[k]);
      end
      reply(8'hA5);
    end
    wait_done(10, ok);
    tick();
    checks++;
    if (!ok || done_cnt - d0 !== 1 || snd_cnt - s0 !== 3) begin
      failures++;
      $display("FAIL basic_pulses: done=%0d snd=%0d required done=1 snd=3", done_cnt - d0, snd_cnt - s0);
    end
    checks++;
    if (cmds_ok !== 8'd3 || err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_end: cmds_ok=%0d err=%b busy=%b required 3/0/0", cmds_ok, err, busy);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] c;
    bit ok;
    int s0;
    push(16'h4BF4);
    push(16'h5BF2);
    pulse_start();
    wait_snd(20, c, ok);
    reply(8'hA5);
    s0 = snd_cnt;
    for (int k = 0; k < 3; k++) begin
      wait_snd(400, c, ok);
      checks++;
      if (!ok || c !== 16'h4BF4) begin
        failures++;
        $display("FAIL to_cmd%0d: seen=%b cmd=%h required 4bf4", k, ok, c);
      end
      if (k > 0) begin
        checks++;
        if (t_snd - t_snt < 200 || t_snd - t_snt > 210) begin
          failures++;
          $display("FAIL to_gap%0d: got %0d cycles required 200..210", k, t_snd - t_snt);
        end
      end
      send_snt();
    end
    wait_err(400, ok);
    checks++;
    if (!ok || err_code !== 2'b10 || busy !== 1'b0) begin
      failures++;
      $display("FAIL to_err: err=%b code=%0d busy=%b required 1/2/0", err, err_code, busy);
    end
    checks++;
    if (snd_cnt - s0 !== 3 || q_cnt !== 5'd1) begin
      failures++;
      $display("FAIL to_count: snd=%0d q_cnt=%0d required 3/1", snd_cnt - s0, q_cnt);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    checks++;
    if (q_cnt !== 5'd0 || err !== 1'b1 || err_code !== 2'b10) begin
      failures++;
      $display("FAIL to_abort: q_cnt=%0d err=%b code=%0d required 0/1/2", q_cnt, err, err_code);
    end
  endtask

  task automatic test_nak_resume();
    logic [15:0] c;
    bit ok;
    push(16'h4BF4);
    push(16'h5BF2);
    push(16'h6A3C);
    pulse_start();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL nak_start_clr: err=%b required 0", err);
    end
    wait_snd(20, c, ok);
    reply(8'hA5);
    wait_snd(20, c, ok);
    checks++;
    if (!ok || c !== 16'h4BF4 || q_cnt !== 5'd2) begin
      failures++;
      $display("FAIL nak_issue: cmd=%h q_cnt=%0d required 4bf4/2", c, q_cnt);
    end
    reply(8'h5A);
    wait_err(20, ok);
    checks++;
    if (!ok || err_code !== 2'b01 || cmds_ok !== 8'd1 || q_cnt !== 5'd2 || busy !== 1'b0) begin
      failures++;
      $display("FAIL nak_err: code=%0d cmds_ok=%0d q_cnt=%0d busy=%b required 1/1/2/0",
               err_code, cmds_ok, q_cnt, busy);
    end
    pulse_start();
    wait_snd(20, c, ok);
    checks++;
    if (!ok || c !== 16'h5BF2 || err !== 1'b0) begin
      failures++;
      $display("FAIL nak_resume: cmd=%h err=%b required 5bf2/0", c, err);
    end
    reply(8'hA5);
    wait_snd(20, c, ok);
    checks++;
    if (!ok || c !== 16'h6A3C) begin
      failures++;
      $display("FAIL nak_next: cmd=%h required 6a3c", c);
    end
    reply(8'hA5);
    wait_done(10, ok);
    checks++;
    if (!ok || err !== 1'b0) begin
      failures++;
      $display("FAIL nak_done: done_seen=%b err=%b required 1/0", ok, err);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] c;
    bit ok;
    tick();
    for (int i = 0; i < 16; i++) push(16'h1000 + 16'(i));
    checks++;
    if (q_full !== 1'b1 || q_cnt !== 5'd16 || err !== 1'b0) begin
      failures++;
      $display("FAIL ovf_fill: q_full=%b q_cnt=%0d err=%b required 1/16/0", q_full, q_cnt, err);
    end
    push(16'hDEAD);
    checks++;
    if (q_full !== 1'b1 || q_cnt !== 5'd16 || err !== 1'b1 || err_code !== 2'b11) begin
      failures++;
      $display("FAIL ovf_drop: q_full=%b q_cnt=%0d err=%b code=%0d required 1/16/1/3",
               q_full, q_cnt, err, err_code);
    end
    pulse_start();
    wait_snd(20, c, ok);
    reply(8'hA5);
    tick();
    cmd_in = 16'hBEEF;
    cmd_wr = 1'b1;
    tick();
    cmd_wr = 1'b0;
    checks++;
    if (snd_cmd !== 1'b1 || cmd !== 16'h1000 || q_cnt !== 5'd16 || err !== 1'b0) begin
      failures++;
      $display("FAIL ovf_pushpop: snd=%b cmd=%h q_cnt=%0d err=%b required 1/1000/16/0",
               snd_cmd, cmd, q_cnt, err);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (q_cnt !== 5'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ovf_cleanup: q_cnt=%0d busy=%b required 0/0", q_cnt, busy);
    end
  endtask

  task automatic test_abort();
    logic [15:0] c;
    bit ok;
    int d0, s0;
    tick();
    for (int i = 0; i < 6; i++) push(16'h3000 + 16'(i));
    pulse_start();
    wait_snd(20, c, ok);
    reply(8'hA5);
    wait_snd(20, c, ok);
    send_snt();
    tick();
    checks++;
    if (!ok || c !== 16'h3000 || q_cnt !== 5'd5) begin
      failures++;
      $display("FAIL abort_setup: cmd=%h q_cnt=%0d required 3000/5", c, q_cnt);
    end
    d0 = done_cnt;
    s0 = snd_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (q_cnt !== 5'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_flush: q_cnt=%0d busy=%b required 0/0", q_cnt, busy);
    end
    resp = 8'hA5;
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (cmds_ok !== 8'd1 || done_cnt !== d0 || snd_cnt !== s0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_late_resp: cmds_ok=%0d done=%0d snd=%0d busy=%b required 1/0/0/0",
               cmds_ok, done_cnt - d0, snd_cnt - s0, busy);
    end
  endtask

  task automatic test_rst_mid();
    logic [15:0] c;
    bit ok;
    int s0;
    push(16'h7777);
    push(16'h8888);
    pulse_start();
    wait_snd(20, c, ok);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({cmd, snd_cmd, busy, done, err, err_code} !== 22'h0 || cmds_ok !== 8'd0 ||
        q_cnt !== 5'd0 || q_full !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid: cmd=%h snd=%b busy=%b done=%b err=%b code=%0d ok=%0d q_cnt=%0d required zeros",
               cmd, snd_cmd, busy, done, err, err_code, cmds_ok, q_cnt);
    end
    s0 = snd_cnt;
    send_snt();
    for (int i = 0; i < 300; i++) tick();
    checks++;
    if (snd_cnt !== s0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_quiet: snd=%0d busy=%b required 0/0", snd_cnt - s0, busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_in = '0;
    cmd_wr = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cmd_snt = 1'b0;
    resp_rdy = 1'b0;
    resp = '0;
    test_reset();
    test_basic_run();
    test_timeout();
    test_nak_resume();
    test_overflow();
    test_abort();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
